// File: rtl/game_tick_gen.sv
// Multi-channel programmable tick generator: per-channel square wave, one-cycle
// tick pulse on every wave toggle, and sticky one-shot expiry flag.
module game_tick_gen #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 27,
  parameter int SEL_W        = 2,
  parameter int DEFAULT_HALF = 37500000
) (
  input  logic                clk1s,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic [CHANNELS-1:0] mode_oneshot,
  input  logic                pause,
  input  logic                load,
  input  logic [SEL_W-1:0]    load_idx,
  input  logic [CNT_W-1:0]    half_val,
  output logic [CHANNELS-1:0] wave,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] done
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CHANNELS-1:0][CNT_W-1:0] h_q;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q;
  logic [CHANNELS-1:0]            load_hit;
  logic [CHANNELS-1:0]            expire;
  logic [CNT_W-1:0]               half_eff;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    half_eff = (half_val == '0) ? ONE : half_val;
    load_hit = '0;
    expire   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Indices >= CHANNELS never match, so such loads fall through harmlessly.
      load_hit[i] = load && (load_idx == SEL_W'(i));
      expire[i]   = (cnt_q[i] == h_q[i] - ONE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every channel sees
  // the pre-edge values of all registers, independent of statement order.
  always_ff @(posedge clk1s) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst_n) begin
        h_q[i]   <= HALF_RST;
        cnt_q[i] <= '0;
        wave[i]  <= 1'b0;
        tick[i]  <= 1'b0;
        done[i]  <= 1'b0;
      end else if (load_hit[i]) begin
        // A load restarts the interval and wins over a coincident expiry.
        h_q[i]   <= half_eff;
        cnt_q[i] <= '0;
        done[i]  <= 1'b0;
        tick[i]  <= 1'b0;
      end else if (!ch_en[i]) begin
        cnt_q[i] <= '0;
        wave[i]  <= 1'b0;
        done[i]  <= 1'b0;
        tick[i]  <= 1'b0;
      end else if (pause || done[i]) begin
        tick[i]  <= 1'b0;
      end else if (expire[i]) begin
        cnt_q[i] <= '0;
        wave[i]  <= ~wave[i];
        tick[i]  <= 1'b1;
        done[i]  <= mode_oneshot[i];
      end else begin
        cnt_q[i] <= cnt_q[i] + ONE;
        tick[i]  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_tick_gen.sv
// Scoreboard bench for game_tick_gen: stimulus pushes expected tick events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_game_tick_gen;

  logic       clk1s = 1'b0;
  logic       rst_n;
  logic [3:0] ch_en;
  logic [3:0] mode_oneshot;
  logic       pause;
  logic       load;
  logic [1:0] load_idx;
  logic [7:0] half_val;
  logic [3:0] wave;
  logic [3:0] tick;
  logic [3:0] done;

  game_tick_gen #(
    .CHANNELS    (4),
    .CNT_W       (8),
    .SEL_W       (2),
    .DEFAULT_HALF(5)
  ) dut (
    .clk1s       (clk1s),
    .rst_n       (rst_n),
    .ch_en       (ch_en),
    .mode_oneshot(mode_oneshot),
    .pause       (pause),
    .load        (load),
    .load_idx    (load_idx),
    .half_val    (half_val),
    .wave        (wave),
    .tick        (tick),
    .done        (done)
  );

  always #5 clk1s = ~clk1s;

  typedef struct {
    int         cyc;
    logic [3:0] tick;
    logic [3:0] wave;
    logic [3:0] done;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk1s) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic push(input int c, input logic [3:0] t, input logic [3:0] w, input logic [3:0] d);
    exp_t e;
    e.cyc  = c;
    e.tick = t;
    e.wave = w;
    e.done = d;
    q.push_back(e);
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge clk1s);
  endtask

  // Monitor: a due expectation is compared in full; otherwise no tick may show.
  always @(negedge clk1s) begin
    if (cyc > 0) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("tick_never_seen", 32'(q[0].cyc + 1), 32'(q[0].cyc));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("tick", {28'd0, tick}, {28'd0, e.tick});
        check("wave", {28'd0, wave}, {28'd0, e.wave});
        check("done", {28'd0, done}, {28'd0, e.done});
      end else begin
        check("idle_tick", {28'd0, tick}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 10000", cyc);
    $fatal(1);
  end

  initial begin
    int b;
    rst_n        = 1'b0;
    ch_en        = '0;
    mode_oneshot = '0;
    pause        = 1'b0;
    load         = 1'b0;
    load_idx     = '0;
    half_val     = '0;

    // Reset state
    at(3);
    check("rst_wave", {28'd0, wave}, 32'd0);
    check("rst_tick", {28'd0, tick}, 32'd0);
    check("rst_done", {28'd0, done}, 32'd0);

    // 1: default half of 5 on ch0
    b = cyc;
    rst_n = 1'b1;
    ch_en = 4'b0001;
    push(b + 5,  4'b0001, 4'b0001, 4'b0000);
    push(b + 10, 4'b0001, 4'b0000, 4'b0000);
    push(b + 15, 4'b0001, 4'b0001, 4'b0000);
    at(b + 16);
    check("s1_wave_high", {28'd0, wave}, 32'h1);
    ch_en = 4'b0000;
    at(b + 17);
    check("s1_wave_cleared", {28'd0, wave}, 32'h0);

    // 2: ch2 with h=3, then h=0 (treated as 1), then ch3 load of 7
    b = cyc;
    load = 1'b1; load_idx = 2'd2; half_val = 8'd3;
    at(b + 1);
    load  = 1'b0;
    ch_en = 4'b0100;
    push(b + 4,  4'b0100, 4'b0100, 4'b0000);
    push(b + 7,  4'b0100, 4'b0000, 4'b0000);
    push(b + 10, 4'b0100, 4'b0100, 4'b0000);
    at(b + 10);
    load = 1'b1; load_idx = 2'd2; half_val = 8'd0;
    at(b + 11);
    load_idx = 2'd3; half_val = 8'd7;
    push(b + 12, 4'b0100, 4'b0000, 4'b0000);
    push(b + 13, 4'b0100, 4'b0100, 4'b0000);
    push(b + 14, 4'b0100, 4'b0000, 4'b0000);
    push(b + 15, 4'b0100, 4'b0100, 4'b0000);
    at(b + 12);
    load = 1'b0;
    at(b + 15);
    ch_en = 4'b1000;
    push(b + 22, 4'b1000, 4'b1000, 4'b0000);
    at(b + 23);
    ch_en = 4'b0000;
    at(b + 24);

    // 3: pause for 4 edges mid-count delays the next tick by 4
    b = cyc;
    ch_en = 4'b0001;
    push(b + 5,  4'b0001, 4'b0001, 4'b0000);
    push(b + 14, 4'b0001, 4'b0000, 4'b0000);
    at(b + 7);
    pause = 1'b1;
    at(b + 11);
    pause = 1'b0;
    at(b + 15);
    ch_en = 4'b0000;
    at(b + 16);

    // 4: one-shot on ch1, then a reload restarts it
    b = cyc;
    mode_oneshot = 4'b0010;
    ch_en        = 4'b0010;
    push(b + 5, 4'b0010, 4'b0010, 4'b0010);
    at(b + 15);
    check("s4_done_held", {28'd0, done}, 32'h2);
    check("s4_wave_held", {28'd0, wave}, 32'h2);
    check("s4_no_tick",   {28'd0, tick}, 32'h0);
    load = 1'b1; load_idx = 2'd1; half_val = 8'd5;
    at(b + 16);
    load = 1'b0;
    check("s4_done_cleared", {28'd0, done}, 32'h0);
    check("s4_wave_kept",    {28'd0, wave}, 32'h2);
    push(b + 21, 4'b0010, 4'b0000, 4'b0010);
    at(b + 22);
    ch_en        = 4'b0000;
    mode_oneshot = 4'b0000;
    at(b + 23);
    check("s4_disable_done", {28'd0, done}, 32'h0);

    // 5: load on the expiry edge suppresses the tick; disable mid-count
    b = cyc;
    ch_en = 4'b0001;
    at(b + 4);
    load = 1'b1; load_idx = 2'd0; half_val = 8'd4;
    at(b + 5);
    load = 1'b0;
    push(b + 9, 4'b0001, 4'b0001, 4'b0000);
    at(b + 11);
    ch_en = 4'b0000;
    at(b + 12);
    check("s5_disable_wave", {28'd0, wave}, 32'h0);
    at(b + 13);
    ch_en = 4'b0001;
    push(b + 17, 4'b0001, 4'b0001, 4'b0000);
    at(b + 18);
    ch_en = 4'b0000;
    at(b + 19);

    // 6: reset mid-count restores the default half
    b = cyc;
    load = 1'b1; load_idx = 2'd0; half_val = 8'd3;
    at(b + 1);
    load  = 1'b0;
    ch_en = 4'b0001;
    push(b + 4, 4'b0001, 4'b0001, 4'b0000);
    at(b + 5);
    rst_n = 1'b0;
    at(b + 6);
    check("s6_rst_wave", {28'd0, wave}, 32'h0);
    check("s6_rst_tick", {28'd0, tick}, 32'h0);
    check("s6_rst_done", {28'd0, done}, 32'h0);
    rst_n = 1'b1;
    push(b + 11, 4'b0001, 4'b0001, 4'b0000);
    at(b + 13);
    check("pending_expectations", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_tick_gen.md
# game_tick_gen

Multi-channel programmable tick generator, the parametrised successor to the game's single fixed-rate mole clock divider. It turns the board clock into CHANNELS independent square waves and one-cycle tick pulses. Each channel has a runtime-loadable half-period, so game logic can speed up moles per level, time reaction windows in one-shot mode, and pause all timing. All outputs are synchronous to the board clock. There is no derived clock: consumers use `tick` as a clock enable.

## Interface
- CHANNELS, 4: number of independent channels (1..16).
- CNT_W, 27: counter/half-period width in bits.
- SEL_W, 2: width of `load_idx`; must satisfy 2^SEL_W >= CHANNELS.
- DEFAULT_HALF, 37500000: half-period loaded into every channel at reset (0.75 s at 50 MHz); must fit CNT_W.

- clk1s  in  1  board clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ch_en  in  CHANNELS  per-channel run enable.
- mode_oneshot  in  CHANNELS  1 = channel stops after its first expiry.
- pause  in  1  global freeze of all counters.
- load  in  1  write strobe for a half-period register.
- load_idx  in  SEL_W  channel written by `load`.
- half_val  in  CNT_W  half-period value in clock cycles; 0 is treated as 1.
- wave  out  CHANNELS  square wave per channel, period 2*half.
- tick  out  CHANNELS  one-cycle pulse on every wave toggle.
- done  out  CHANNELS  one-shot expiry flag, sticky.

## Operation
- Per channel state: half register `h`, counter `cnt` (0..h-1), `wave`, `done`, registered `tick`.
- Reset (rst_n=0 at an edge) sets all `h` to DEFAULT_HALF and clears `cnt`, `wave`, `tick` and `done`. Reset mid-count discards all progress.
- Channel priority per edge, highest first:
  - reset;
  - load to this channel: `h`=max(half_val,1), `cnt`=0, `done`=0, `wave` unchanged, no tick;
  - `ch_en`=0: `cnt`=0, `wave`=0, `done`=0, no tick;
  - `pause`=1: everything held, no tick;
  - `done`=1: held, no tick;
  - count.
- Count step:
  - If `cnt`==`h`-1 (expiry): `cnt`=0, `wave` toggles, `tick`=1 for the next cycle, and `done`=1 if `mode_oneshot` is set.
  - Otherwise `cnt`++ and `tick`=0.
- A load with load_idx >= CHANNELS is ignored. A load affects only the addressed channel.
- Load and expiry on the same channel at the same edge: load wins and no tick is issued.
- `mode_oneshot` is sampled at expiry. Changing it mid-count only affects the next expiry.
- `h`=1: expires every enabled cycle, so `tick` stays high continuously and `wave` toggles every cycle.
- `cnt` never exceeds `h`-1. No arithmetic overflow is possible when `h` fits CNT_W.

## Timing
- With `ch_en` rising and the channel idle (`cnt`=0), the first expiry occurs at the h-th enabled, unpaused edge. `tick`/`wave` change at that edge.
- Later expiries occur every h enabled edges. `wave` period is 2h cycles with a 50% duty cycle.
- Each paused cycle extends the current interval by exactly one cycle.
- A new `h` takes effect from the edge after the load. The interval restarts from 0.
- `tick` is registered and is high for exactly one cycle per expiry, except when h=1.
- Outputs after reset: `wave`=0, `tick`=0, `done`=0.

## Test plan
Parameters for all scenarios: CHANNELS=4, CNT_W=8, DEFAULT_HALF=5.
1. Reset, then ch_en=0001 -> tick[0] pulses after edges 5, 10, 15; wave[0] toggles there (period 10); the other channels stay 0.
2. Load idx=2 val=3, then ch_en=0100 -> tick[2] every 3 cycles. A load with val=0 -> tick[2] every cycle. A load with idx=3, val=7 leaves ch2 unchanged.
3. ch0 running with h=5 and pause held for 4 cycles mid-count -> next tick arrives 4 cycles later than scheduled; no tick during the pause.
4. mode_oneshot[1]=1, ch_en[1]=1, h=5 -> a single tick after edge 5, done[1]=1, wave[1]=1 held. A load to ch1 -> done[1]=0 and counting restarts.
5. Load ch0 on the same edge as its expiry -> no tick, cnt=0, new h applies. Drop ch_en[0] mid-count -> wave[0]=0, and re-enable gives a full h interval.
6. rst_n=0 mid-count with h=3 loaded -> all outputs 0 next cycle and h back to 5, with the first tick 5 edges after reset release.
